fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined RV64 core. It owns the program counter, drives the combinational instruction-memory read, and registers the fetched word into the IF/ID pipeline register for decode. It also applies hazard stalls, applies branch redirects and flushes from downstream, and detects the all-zero halt word to generate `end_program` once the pipeline has drained.

## Interface

**Parameters**
- `PC_WIDTH`, 64: program-counter and address width.
- `RESET_PC`, 0: PC value loaded on reset.
- `DRAIN_CYCLES`, 4: cycles, after the halt word is latched into IF/ID, until `end_program` asserts. Legal range 1..15.

**Ports** (clock and reset first)
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `stall` input 1: hazard stall; holds the PC and IF/ID.
- `flush` input 1: replaces IF/ID contents with a bubble.
- `branch_taken` input 1: redirect request from EX.
- `branch_target` input PC_WIDTH: redirect address; byte address with bits [1:0] = 0.
- `imem_addr` output PC_WIDTH: byte address to instruction memory; equals `pc_current`.
- `imem_data` input 32: combinational read data, `memory[imem_addr>>2]`.
- `pc_current` output PC_WIDTH: current fetch PC.
- `if_id_pc` output PC_WIDTH: PC of the instruction held in IF/ID.
- `if_id_instr` output 32: instruction held in IF/ID.
- `if_id_valid` output 1: IF/ID holds a real instruction.
- `end_program` output 1: program finished and pipeline drained; sticky until reset.

## Operation

**State machine:** RUN, DRAIN, HALTED.

**Per-cycle priority in RUN:** reset > `branch_taken` > `stall` > `flush` > normal.
- `branch_taken`: PC ← `branch_target`. IF/ID gets a bubble: instr = 0x00000013, valid = 0, pc = 0.
- `stall` (no branch): PC and IF/ID hold.
- `flush` (no branch, no stall): IF/ID gets a bubble; PC ← PC+4.
- Normal: IF/ID ← {`pc_current`, `imem_data`, valid = 1}; PC ← PC+4.
  - If `imem_data` == 0 (halt word), the PC holds, the halt word enters IF/ID with valid = 0, the drain counter loads `DRAIN_CYCLES`, and the state moves to DRAIN.

**DRAIN**
- The PC holds and IF/ID inserts a bubble each cycle.
- The counter decrements on each cycle without `stall`, and pauses during `stall`.
- When the counter reaches 0, the state moves to HALTED.
- `branch_taken` in DRAIN means the halt was fetched in a branch shadow: the state returns to RUN, PC ← `branch_target`, IF/ID gets a bubble, and the counter is cleared.

**HALTED**
- `end_program` = 1.
- PC, IF/ID and state hold. All inputs are ignored except `reset`.

**Arithmetic**
- PC+4 wraps modulo 2^PC_WIDTH with no flag.
- `branch_target` bits [1:0] are forced to 0 on load.

## Timing

**Reset values:** `pc_current` = `RESET_PC`, `if_id_pc` = 0, `if_id_instr` = 0x00000013, `if_id_valid` = 0, `end_program` = 0, state = RUN, counter = 0.

**Latency**
- The word at `pc_current` appears on `if_id_instr` one cycle later.
- A redirect takes effect on `pc_current` the cycle after `branch_taken` is sampled, with exactly one bubble in IF/ID.

**`end_program` timing:** asserts `DRAIN_CYCLES` non-stalled cycles after the halt word is latched into IF/ID.

**Boundary and simultaneous events**
- `stall` and `branch_taken` together: the branch wins and the stall is dropped for that cycle.
- `flush` and `stall` together: stall wins.
- A halt word fetched while `stall` = 1 is not detected until the stall releases.
- A halt word fetched while `flush` = 1 is not detected.
- Reset in any state, including mid-DRAIN or in HALTED, returns all state to the reset values on the next edge.

## Configuration

**`FETCH_PERF_EN` defined:**
- Adds output ports `fetch_count` [31:0] and `stall_count` [31:0], both reset to 0 and saturating at 0xFFFFFFFF.
- `fetch_count` increments on each normal valid IF/ID load.
- `stall_count` increments on each cycle with `stall` = 1 and no branch in RUN or DRAIN.

**`FETCH_PERF_EN` undefined:** neither port nor either counter exists. All other behaviour is identical.

## Test plan

1. **Reset:** hold `reset` for 2 cycles, then release → `pc_current` = 0, `if_id_instr` = 0x00000013, `if_id_valid` = 0, `end_program` = 0.
2. **Straight-line fetch:** memory[0..2] = 0x00400293, 0x00400313, 0x00400393; no stalls → `if_id_instr` shows those three words on cycles 1, 2, 3 with `if_id_pc` = 0, 4, 8.
3. **Branch redirect:** memory[0] = 0x00000863; pulse `branch_taken` with target 0x10 in cycle 2 → `pc_current` = 0x10 in cycle 3, with one bubble (valid = 0) in IF/ID.
4. **Stall:** assert `stall` for 3 cycles at PC = 4 → PC holds at 4 and `if_id_instr` holds 0x00400293; fetch resumes at 8.
5. **Halt with stall:** memory[4] = 0, `DRAIN_CYCLES` = 4, one stall cycle during DRAIN → `end_program` rises exactly 5 cycles after the halt word is latched and stays high; `pc_current` stays at 0x10.
6. **Halt in branch shadow:** halt word latched, then `branch_taken` to 0x4 in DRAIN → state RUN, `end_program` stays 0, and fetch resumes at 0x4.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, registers fetched words into IF/ID and
// drains the pipeline after the all-zero halt word. Optional FETCH_PERF_EN adds perf counters.
module fetch_stage #(
    parameter int unsigned          PC_WIDTH     = 64,
    parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
    parameter int unsigned          DRAIN_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_data,
    output logic [PC_WIDTH-1:0] pc_current,
    output logic [PC_WIDTH-1:0] if_id_pc,
    output logic [31:0]         if_id_instr,
    output logic                if_id_valid,
    output logic                end_program
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         stall_count
`endif
);

    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
    localparam logic [31:0] HALT_WORD  = 32'h0000_0000;
    localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t              state, state_n;
    logic [3:0]          drain_cnt, drain_cnt_n;
    logic [PC_WIDTH-1:0] pc_n, if_id_pc_n;
    logic [31:0]         if_id_instr_n;
    logic                if_id_valid_n;
    logic                fetch_event, stall_event;

    logic [PC_WIDTH-1:0] pc_plus4, target_aligned;
    assign pc_plus4       = pc_current + PC_WIDTH'(4);
    assign target_aligned = branch_target & ~PC_WIDTH'(3);

    assign imem_addr   = pc_current;
    assign end_program = (state == HALTED);

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_n       = state;
        drain_cnt_n   = drain_cnt;
        pc_n          = pc_current;
        if_id_pc_n    = if_id_pc;
        if_id_instr_n = if_id_instr;
        if_id_valid_n = if_id_valid;
        fetch_event   = 1'b0;
        stall_event   = 1'b0;

        case (state)
            RUN: begin
                if (branch_taken) begin
                    pc_n          = target_aligned;
                    if_id_pc_n    = '0;
                    if_id_instr_n = NOP_WORD;
                    if_id_valid_n = 1'b0;
                end else if (stall) begin
                    stall_event = 1'b1;
                end else if (flush) begin
                    pc_n          = pc_plus4;
                    if_id_pc_n    = '0;
                    if_id_instr_n = NOP_WORD;
                    if_id_valid_n = 1'b0;
                end else if (imem_data == HALT_WORD) begin
                    // Halt word parks in IF/ID as invalid; PC stays on it.
                    if_id_pc_n    = pc_current;
                    if_id_instr_n = HALT_WORD;
                    if_id_valid_n = 1'b0;
                    drain_cnt_n   = DRAIN_LOAD;
                    state_n       = DRAIN;
                end else begin
                    pc_n          = pc_plus4;
                    if_id_pc_n    = pc_current;
                    if_id_instr_n = imem_data;
                    if_id_valid_n = 1'b1;
                    fetch_event   = 1'b1;
                end
            end
            DRAIN: begin
                if_id_pc_n    = '0;
                if_id_instr_n = NOP_WORD;
                if_id_valid_n = 1'b0;
                if (branch_taken) begin
                    // Halt came from a branch shadow: resume at the target.
                    pc_n        = target_aligned;
                    drain_cnt_n = '0;
                    state_n     = RUN;
                end else if (stall) begin
                    stall_event = 1'b1;
                end else if (drain_cnt <= 4'd1) begin
                    drain_cnt_n = '0;
                    state_n     = HALTED;
                end else begin
                    drain_cnt_n = drain_cnt - 4'd1;
                end
            end
            HALTED: ;
            default: state_n = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            drain_cnt   <= '0;
            pc_current  <= RESET_PC;
            if_id_pc    <= '0;
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
        end else begin
            state       <= state_n;
            drain_cnt   <= drain_cnt_n;
            pc_current  <= pc_n;
            if_id_pc    <= if_id_pc_n;
            if_id_instr <= if_id_instr_n;
            if_id_valid <= if_id_valid_n;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (fetch_event && fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
            if (stall_event && stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
        end
    end
`else
    logic unused_events;
    assign unused_events = fetch_event ^ stall_event;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, straight-line fetch, redirect,
// stall/flush interaction, halt drain timing and halt in a branch shadow.
module tb_fetch_stage;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          flush;
    logic          branch_taken;
    logic [W-1:0]  branch_target;
    logic [W-1:0]  imem_addr;
    logic [31:0]   imem_data;
    logic [W-1:0]  pc_current;
    logic [W-1:0]  if_id_pc;
    logic [31:0]   if_id_instr;
    logic          if_id_valid;
    logic          end_program;
`ifdef FETCH_PERF_EN
    logic [31:0]   fetch_count;
    logic [31:0]   stall_count;
`endif

    int tests  = 0;
    int failed = 0;

    logic [31:0] mem [0:63];
    assign imem_data = (imem_addr < 64'd256) ? mem[imem_addr[7:2]] : 32'h0000_0013;

    always #5 clk = ~clk;

    fetch_stage #(.PC_WIDTH(W), .RESET_PC('0), .DRAIN_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .pc_current   (pc_current),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .end_program  (end_program)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count  (fetch_count),
        .stall_count  (stall_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_nops();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        load_nops();
        do_reset();
        tests++; if (pc_current !== 64'h0) begin failed++; $display("FAIL reset_pc got %h want %h", pc_current, 64'h0); end
        tests++; if (if_id_instr !== 32'h13) begin failed++; $display("FAIL reset_instr got %h want %h", if_id_instr, 32'h13); end
        tests++; if (if_id_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b want 0", if_id_valid); end
        tests++; if (end_program !== 1'b0) begin failed++; $display("FAIL reset_end got %b want 0", end_program); end
        tests++; if (if_id_pc !== 64'h0) begin failed++; $display("FAIL reset_ifid_pc got %h want 0", if_id_pc); end
    endtask

    task automatic test_straight_line();
        logic [31:0] words [0:2];
        words[0] = 32'h0040_0293; words[1] = 32'h0040_0313; words[2] = 32'h0040_0393;
        load_nops();
        for (int i = 0; i < 3; i++) mem[i] = words[i];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (if_id_instr !== words[i]) begin failed++; $display("FAIL straight_instr%0d got %h want %h", i, if_id_instr, words[i]); end
            tests++; if (if_id_pc !== 64'(4*i)) begin failed++; $display("FAIL straight_ifid_pc%0d got %h want %h", i, if_id_pc, 64'(4*i)); end
            tests++; if (if_id_valid !== 1'b1) begin failed++; $display("FAIL straight_valid%0d got %b want 1", i, if_id_valid); end
            tests++; if (pc_current !== 64'(4*i+4)) begin failed++; $display("FAIL straight_pc%0d got %h want %h", i, pc_current, 64'(4*i+4)); end
        end
    endtask

    task automatic test_branch();
        load_nops();
        mem[0] = 32'h0000_0863;
        do_reset();
        step();
        tests++; if (if_id_instr !== 32'h0000_0863) begin failed++; $display("FAIL br_first_instr got %h want %h", if_id_instr, 32'h0000_0863); end
        step();
        branch_taken = 1'b1; branch_target = 64'h10;
        step();
        branch_taken = 1'b0;
        tests++; if (pc_current !== 64'h10) begin failed++; $display("FAIL br_pc got %h want %h", pc_current, 64'h10); end
        tests++; if (if_id_valid !== 1'b0) begin failed++; $display("FAIL br_bubble_valid got %b want 0", if_id_valid); end
        tests++; if (if_id_instr !== 32'h13) begin failed++; $display("FAIL br_bubble_instr got %h want %h", if_id_instr, 32'h13); end
        tests++; if (if_id_pc !== 64'h0) begin failed++; $display("FAIL br_bubble_pc got %h want 0", if_id_pc); end
        step();
        tests++; if (if_id_pc !== 64'h10 || if_id_valid !== 1'b1) begin failed++; $display("FAIL br_resume got pc %h valid %b want pc 10 valid 1", if_id_pc, if_id_valid); end
        // Branch with simultaneous stall and a misaligned target.
        branch_taken = 1'b1; stall = 1'b1; branch_target = 64'h23;
        step();
        branch_taken = 1'b0; stall = 1'b0;
        tests++; if (pc_current !== 64'h20) begin failed++; $display("FAIL br_stall_pc got %h want %h", pc_current, 64'h20); end
        tests++; if (if_id_valid !== 1'b0) begin failed++; $display("FAIL br_stall_valid got %b want 0", if_id_valid); end
    endtask

    task automatic test_stall_flush();
        load_nops();
        mem[0] = 32'h0040_0293; mem[1] = 32'h0040_0313; mem[2] = 32'h0040_0393; mem[3] = 32'h0;
        do_reset();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            step();
            tests++; if (pc_current !== 64'h4) begin failed++; $display("FAIL stall_pc%0d got %h want %h", i, pc_current, 64'h4); end
            tests++; if (if_id_instr !== 32'h0040_0293 || if_id_valid !== 1'b1) begin failed++; $display("FAIL stall_ifid%0d got %h/%b want 00400293/1", i, if_id_instr, if_id_valid); end
        end
        stall = 1'b0; flush = 1'b0;
        step();
        tests++; if (pc_current !== 64'h8) begin failed++; $display("FAIL stall_resume_pc got %h want %h", pc_current, 64'h8); end
        tests++; if (if_id_instr !== 32'h0040_0313 || if_id_pc !== 64'h4) begin failed++; $display("FAIL stall_resume_ifid got %h@%h want 00400313@4", if_id_instr, if_id_pc); end
        flush = 1'b1;
        step();
        tests++; if (pc_current !== 64'hC || if_id_valid !== 1'b0) begin failed++; $display("FAIL flush_pc got %h valid %b want c 0", pc_current, if_id_valid); end
        step();
        flush = 1'b0;
        tests++; if (pc_current !== 64'h10) begin failed++; $display("FAIL flush_halt_pc got %h want %h", pc_current, 64'h10); end
        tests++; if (if_id_instr !== 32'h13 || if_id_valid !== 1'b0) begin failed++; $display("FAIL flush_halt_ifid got %h/%b want 13/0", if_id_instr, if_id_valid); end
        step();
        tests++; if (if_id_pc !== 64'h10 || if_id_valid !== 1'b1 || end_program !== 1'b0) begin failed++; $display("FAIL flush_halt_ignored got %h/%b end %b want 10/1 end 0", if_id_pc, if_id_valid, end_program); end
    endtask

    task automatic test_halt_stall();
        load_nops();
        mem[4] = 32'h0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        tests++; if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc !== 64'h10) begin failed++; $display("FAIL halt_latch got %h/%b@%h want 0/0@10", if_id_instr, if_id_valid, if_id_pc); end
        tests++; if (pc_current !== 64'h10) begin failed++; $display("FAIL halt_latch_pc got %h want %h", pc_current, 64'h10); end
        for (int i = 1; i <= 5; i++) begin
            stall = (i == 2);
            step();
            if (i < 5) begin
                tests++; if (end_program !== 1'b0) begin failed++; $display("FAIL halt_early_end%0d got %b want 0", i, end_program); end
            end
        end
        stall = 1'b0;
        tests++; if (end_program !== 1'b1) begin failed++; $display("FAIL halt_end got %b want 1", end_program); end
        tests++; if (pc_current !== 64'h10 || if_id_instr !== 32'h13) begin failed++; $display("FAIL halt_drain_state got pc %h instr %h want 10 13", pc_current, if_id_instr); end
        branch_taken = 1'b1; branch_target = 64'h40;
        step();
        step();
        branch_taken = 1'b0;
        tests++; if (end_program !== 1'b1 || pc_current !== 64'h10) begin failed++; $display("FAIL halted_hold got end %b pc %h want 1 10", end_program, pc_current); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++; if (end_program !== 1'b0 || pc_current !== 64'h0) begin failed++; $display("FAIL halted_reset got end %b pc %h want 0 0", end_program, pc_current); end
    endtask

    task automatic test_halt_shadow();
        load_nops();
        mem[1] = 32'h0040_0313; mem[2] = 32'h0;
        do_reset();
        step();
        step();
        stall = 1'b1;
        step();
        stall = 1'b0;
        tests++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h0040_0313 || pc_current !== 64'h8) begin failed++; $display("FAIL shadow_stalled_halt got %h/%b pc %h want 00400313/1 pc 8", if_id_instr, if_id_valid, pc_current); end
        step();
        tests++; if (if_id_instr !== 32'h0 || if_id_pc !== 64'h8 || pc_current !== 64'h8) begin failed++; $display("FAIL shadow_latch got %h@%h pc %h want 0@8 pc 8", if_id_instr, if_id_pc, pc_current); end
        step();
        branch_taken = 1'b1; branch_target = 64'h4;
        step();
        branch_taken = 1'b0;
        tests++; if (pc_current !== 64'h4 || if_id_valid !== 1'b0 || end_program !== 1'b0) begin failed++; $display("FAIL shadow_redirect got pc %h valid %b end %b want 4 0 0", pc_current, if_id_valid, end_program); end
        step();
        tests++; if (if_id_instr !== 32'h0040_0313 || if_id_pc !== 64'h4 || if_id_valid !== 1'b1) begin failed++; $display("FAIL shadow_resume got %h@%h/%b want 00400313@4/1", if_id_instr, if_id_pc, if_id_valid); end
        tests++; if (pc_current !== 64'h8 || end_program !== 1'b0) begin failed++; $display("FAIL shadow_resume_pc got %h end %b want 8 0", pc_current, end_program); end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++; if (pc_current !== 64'h0 || if_id_instr !== 32'h13 || if_id_valid !== 1'b0) begin failed++; $display("FAIL drain_reset got pc %h %h/%b want 0 13/0", pc_current, if_id_instr, if_id_valid); end
        step();
        tests++; if (if_id_valid !== 1'b1 || pc_current !== 64'h4) begin failed++; $display("FAIL drain_reset_run got valid %b pc %h want 1 4", if_id_valid, pc_current); end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;
        load_nops();
        test_reset();
        test_straight_line();
        test_branch();
        test_stall_flush();
        test_halt_stall();
        test_halt_shadow();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
